// File: rtl/cpu_defs.sv
// Shared opcode, ALU, write-back select and FSM state encodings for the
// Simple RISC Machine controller.
package cpu_defs;

   localparam logic [2:0] OP_MOV = 3'b110;
   localparam logic [2:0] OP_ALU = 3'b101;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_CMP = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_MVN = 2'b11;

   localparam logic [1:0] VSEL_C     = 2'b00;
   localparam logic [1:0] VSEL_PC    = 2'b01;
   localparam logic [1:0] VSEL_IMM8  = 2'b10;
   localparam logic [1:0] VSEL_MDATA = 2'b11;

   typedef enum logic [2:0] {
      S_WAIT      = 3'd0,
      S_DECODE    = 3'd1,
      S_GET_A     = 3'd2,
      S_GET_B     = 3'd3,
      S_COMPUTE   = 3'd4,
      S_WRITE_REG = 3'd5,
      S_WRITE_IMM = 3'd6
   } state_t;

endpackage

// File: rtl/cpu_ctrl_instr_dec.sv
// Purely combinational field split and immediate sign extension of the
// instruction register.
module instr_dec
   import cpu_defs::*;
(
   input  logic [15:0] ir,
   output logic [2:0]  opcode,
   output logic [1:0]  op,
   output logic [2:0]  rn,
   output logic [2:0]  rd,
   output logic [1:0]  sh,
   output logic [2:0]  rm,
   output logic [15:0] sximm8,
   output logic [15:0] sximm5
);

   assign opcode = ir[15:13];
   assign op     = ir[12:11];
   assign rn     = ir[10:8];
   assign rd     = ir[7:5];
   assign sh     = ir[4:3];
   assign rm     = ir[2:0];
   assign sximm8 = {{8{ir[7]}}, ir[7:0]};
   assign sximm5 = {{11{ir[4]}}, ir[4:0]};

endmodule

// File: rtl/cpu_ctrl.sv
// Instruction register plus Moore sequencing FSM that steps the datapath
// through one micro-operation per cycle for the MOV/ALU instruction subset.
module cpu_ctrl
   import cpu_defs::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] in,
   input  logic        load,
   input  logic        s,
   output logic        w,
   output logic        err,
   output logic [2:0]  readnum,
   output logic [2:0]  writenum,
   output logic [1:0]  vsel,
   output logic        loada,
   output logic        loadb,
   output logic        asel,
   output logic        bsel,
   output logic [1:0]  shift,
   output logic [1:0]  ALUop,
   output logic        loadc,
   output logic        loads,
   output logic        write,
   output logic [15:0] sximm8,
   output logic [15:0] sximm5
);

   state_t      state_q, state_d;
   logic [15:0] ir_q, ir_d;
   logic        err_q, err_d;

   logic [2:0]  opcode;
   logic [1:0]  op;
   logic [2:0]  rn, rd, rm;
   logic [1:0]  sh;

   instr_dec u_dec (
      .ir     (ir_q),
      .opcode (opcode),
      .op     (op),
      .rn     (rn),
      .rd     (rd),
      .sh     (sh),
      .rm     (rm),
      .sximm8 (sximm8),
      .sximm5 (sximm5)
   );

   assign err = err_q;

   always_comb begin
      state_d  = state_q;
      ir_d     = ir_q;
      err_d    = err_q;
      w        = 1'b0;
      readnum  = 3'd0;
      writenum = 3'd0;
      vsel     = VSEL_C;
      loada    = 1'b0;
      loadb    = 1'b0;
      asel     = 1'b0;
      bsel     = 1'b0;
      shift    = sh;
      ALUop    = ALU_ADD;
      loadc    = 1'b0;
      loads    = 1'b0;
      write    = 1'b0;

      case (state_q)
         S_WAIT: begin
            w = 1'b1;
            // A load on the same edge as s means the new word is executed.
            if (load) ir_d = in;
            if (s) begin
               state_d = S_DECODE;
               err_d   = 1'b0;
            end
         end
         S_DECODE: begin
            if (opcode == OP_MOV && op == 2'b10)      state_d = S_WRITE_IMM;
            else if (opcode == OP_MOV && op == 2'b00) state_d = S_GET_B;
            else if (opcode == OP_ALU)                state_d = S_GET_A;
            else begin
               state_d = S_WAIT;
               err_d   = 1'b1;
            end
         end
         S_GET_A: begin
            readnum = rn;
            loada   = 1'b1;
            state_d = S_GET_B;
         end
         S_GET_B: begin
            readnum = rm;
            loadb   = 1'b1;
            state_d = S_COMPUTE;
         end
         S_COMPUTE: begin
            // MOV-reg passes the shifted B operand through A=0 via asel.
            if (opcode == OP_MOV) begin
               asel    = 1'b1;
               ALUop   = ALU_ADD;
               loadc   = 1'b1;
               state_d = S_WRITE_REG;
            end else if (op == ALU_CMP) begin
               ALUop   = ALU_CMP;
               loads   = 1'b1;
               state_d = S_WAIT;
            end else begin
               ALUop   = op;
               loadc   = 1'b1;
               state_d = S_WRITE_REG;
            end
         end
         S_WRITE_REG: begin
            writenum = rd;
            vsel     = VSEL_C;
            write    = 1'b1;
            state_d  = S_WAIT;
         end
         S_WRITE_IMM: begin
            writenum = rn;
            vsel     = VSEL_IMM8;
            write    = 1'b1;
            state_d  = S_WAIT;
         end
         default: state_d = S_WAIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_WAIT;
         ir_q    <= 16'h0000;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         err_q   <= err_d;
      end
   end

endmodule
